sw_linear_array: RTL and testbench
==================================

// Module: sw_linear_array
// PURPOSE
//  Parametrised Smith-Waterman linear systolic array: holds one read segment of up to N_PE bases (one
//  per PE), streams reference bases through with valid/ready, computes local-alignment scores H(i,j) and
//  reports best score and its (i,j) end coordinates. Successor of the fixed 16-PE core: runtime read
//  length, per-base flow control with bubbles, saturating arithmetic, best-cell tracking.
// PARAMETERS
//  N_PE     16  number of PEs = max read bases per run
//  SCORE_W  16  unsigned score width
//  PEN_W    3   width of match/mismatch/gap inputs
//  COORD_W  16  width of column counter and best_j_o
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             asynchronous, active-high reset
//  start_i       in   1             start pulse; sampled in IDLE only
//  read_len_i    in   $clog2(N_PE+1) valid read bases, 1..N_PE; latched at start
//  read_bases_i  in   2*N_PE        base i at [2i+1:2i]; A=00 C=01 G=10 T=11; latched at start
//  match_i       in   PEN_W         match reward; latched at start
//  mismatch_i    in   PEN_W         mismatch penalty; latched at start
//  gap_i         in   PEN_W         linear gap penalty; latched at start
//  ref_valid_i   in   1             ref base valid
//  ref_base_i    in   2             ref base
//  ref_last_i    in   1             qualifies final ref base
//  ref_ready_o   out  1             high only in RUN
//  busy_o        out  1             high in RUN and DRAIN
//  done_o        out  1             one-cycle pulse, results valid
//  best_score_o  out  SCORE_W       max H over run
//  best_i_o      out  $clog2(N_PE)  read index of best cell
//  best_j_o      out  COORD_W       ref index (0-based, counts accepted bases only)
//  overflow_o    out  1             sticky: some H saturated this run
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; PE H/valid regs, column counter, best regs cleared.
//  FSM: IDLE -start_i-> RUN (latch cfg, clear PEs, best, overflow, j=0); RUN -handshake with
//   ref_last_i-> DRAIN; DRAIN -all PE valids clear and final max compare registered-> DONE;
//   DONE -> IDLE after 1 cycle (done_o=1). start_i outside IDLE ignored.
//  Handshake: accept when ref_valid_i & ref_ready_o; j increments per accept. No valid: bubble
//   enters PE0, no PE state changes for that token.
//  PE k (k<read_len): on valid token (base r, column j) from left with H(k-1,j), Hdiag=H(k-1,j-1):
//   H(k,j)=max(0, Hdiag+/-score, H(k-1,j)-gap, H(k,j-1)-gap); +match if r==read[k], else -mismatch.
//   Left boundary of PE0: H(-1,*)=0. Registered; token reaches PE k k cycles after PE0.
//  PEs k>=read_len pass tokens, H forced 0, excluded from max.
//  Arithmetic: SCORE_W+1-bit intermediates; negative clamps to 0; >2^SCORE_W-1 saturates, sets overflow_o.
//  Best update: strictly greater only (first hit kept); same-cycle ties -> lowest PE index. All-zero
//   matrix -> score 0, i=0, j=0.
//  Latency: done_o high exactly N_PE+2 cycles after the ref_last handshake edge; best_* held stable
//   until next start accepted.
//  Reset mid-run: immediate return to IDLE, in-flight tokens discarded, no done_o.
//  j wraps modulo 2^COORD_W; no flag.
// STRUCTURE
//  sw_pkg: base encodings, FSM state enum (IDLE/RUN/DRAIN/DONE), saturating add/sub functions.
//  Sub-module sw_pe (one cell: base reg, H/Hdiag regs, valid reg, score cell), generated N_PE times;
//  top holds FSM, cfg latch, column counter, registered max-reduction tree.
// TESTING (N_PE=4, SCORE_W=16, match=2 mismatch=1 gap=2 unless noted)
//  read ACGT len 4, ref ACGT contiguous -> best 8, i=3, j=3, done_o 6 cycles after last, overflow 0.
//  read AAAA, ref TTTT -> best 0, i=0, j=0, done_o pulses once.
//  same as case 1 with ref_valid_i toggling every other cycle -> identical results, j counts 4.
//  read_len=2 read AC.., ref ACAC -> best 4, i=1, j=1 (PEs 2,3 ignored); then j=3 equal 4 not taken.
//  SCORE_W=4, match=7, read AAAA ref AAAA -> best 15, overflow_o=1.
//  rst mid-RUN, then start_i twice (2nd while busy) -> only one run, results match case 1.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman linear array: base codes, FSM states, score helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package sw_pkg;

  // 2-bit nucleotide encodings
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Score helpers work on a fixed wide type. Callers zero-extend their
  // SCORE_W-bit values into it and pass their own ceiling.
  localparam int unsigned SAT_W = 32;
  typedef logic [SAT_W-1:0] wide_t;

  // Returns {saturated, min(a+b, max_v)}
  function automatic logic [SAT_W:0] sat_add(input wide_t a, input wide_t b, input wide_t max_v);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      sat_add = {1'b1, max_v};
    end else begin
      sat_add = sum;
    end
  endfunction

  // Returns max(a-b, 0)
  function automatic wide_t sat_sub(input wide_t a, input wide_t b);
    sat_sub = (a > b) ? (a - b) : '0;
  endfunction

  function automatic wide_t max3(input wide_t a, input wide_t b, input wide_t c);
    wide_t m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sw_pe.sv
// One systolic cell: scores its read base against each passing reference token.
// Latency: 1 cycle from token in to token out (with the new H for this cell).
// Backpressure: none; a bubble (in_vld_i=0) leaves all score state untouched.
module sw_pe
  import sw_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int PEN_W   = 3,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [1:0]         read_base_i,
  input  logic [PEN_W-1:0]   match_i,
  input  logic [PEN_W-1:0]   mismatch_i,
  input  logic [PEN_W-1:0]   gap_i,
  input  logic               in_vld_i,
  input  logic [1:0]         in_base_i,
  input  logic [COORD_W-1:0] in_col_i,
  input  logic [SCORE_W-1:0] in_h_i,
  output logic               out_vld_o,
  output logic [1:0]         out_base_o,
  output logic [COORD_W-1:0] out_col_o,
  output logic [SCORE_W-1:0] out_h_o,
  output logic               out_ovf_o
);

  localparam wide_t H_MAX = wide_t'({SCORE_W{1'b1}});

  logic               vld_q;
  logic [1:0]         base_q;
  logic [COORD_W-1:0] col_q;
  logic [SCORE_W-1:0] h_q;      // H(k,j) of the last token; is H(k,j-1) for the next one
  logic [SCORE_W-1:0] hdiag_q;  // H(k-1,j-1): upstream H seen with the previous token
  logic               ovf_q;

  wide_t              diag_w;
  wide_t              up_w;
  wide_t              left_w;
  logic               diag_ovf;
  logic [SCORE_W-1:0] h_d;
  logic               ovf_d;

  // Cell recurrence; only the diagonal reward can push past the ceiling
  always_comb begin
    diag_w   = '0;
    diag_ovf = 1'b0;
    if (in_base_i == read_base_i) begin
      {diag_ovf, diag_w} = sat_add(wide_t'(hdiag_q), wide_t'(match_i), H_MAX);
    end else begin
      diag_w = sat_sub(wide_t'(hdiag_q), wide_t'(mismatch_i));
    end
    up_w   = sat_sub(wide_t'(in_h_i), wide_t'(gap_i));
    left_w = sat_sub(wide_t'(h_q), wide_t'(gap_i));
    h_d    = en_i ? SCORE_W'(max3(diag_w, up_w, left_w)) : '0;
    ovf_d  = en_i & diag_ovf;
  end

  // Token and score registers; clr_i starts a fresh matrix (boundary H = 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      base_q  <= '0;
      col_q   <= '0;
      h_q     <= '0;
      hdiag_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      vld_q   <= 1'b0;
      h_q     <= '0;
      hdiag_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q <= in_vld_i;
      if (in_vld_i) begin
        base_q  <= in_base_i;
        col_q   <= in_col_i;
        hdiag_q <= in_h_i;
        h_q     <= h_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_vld_o  = vld_q;
  assign out_base_o = base_q;
  assign out_col_o  = col_q;
  assign out_h_o    = h_q;
  assign out_ovf_o  = ovf_q;

endmodule

// File: rtl/sw_linear_array.sv
// Smith-Waterman linear array: one read base per PE, reference streamed through, best H and (i,j) reported.
// Latency: done_o rises N_PE+2 cycles after the ref_last handshake edge.
// Backpressure: ref_ready_o high only in RUN; gaps in ref_valid_i become bubbles in the pipe.
module sw_linear_array
  import sw_pkg::*;
#(
  parameter int N_PE    = 16,
  parameter int SCORE_W = 16,
  parameter int PEN_W   = 3,
  parameter int COORD_W = 16,
  localparam int LEN_W  = $clog2(N_PE + 1),
  localparam int IDX_W  = $clog2(N_PE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [LEN_W-1:0]    read_len_i,
  input  logic [2*N_PE-1:0]   read_bases_i,
  input  logic [PEN_W-1:0]    match_i,
  input  logic [PEN_W-1:0]    mismatch_i,
  input  logic [PEN_W-1:0]    gap_i,
  input  logic                ref_valid_i,
  input  logic [1:0]          ref_base_i,
  input  logic                ref_last_i,
  output logic                ref_ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [SCORE_W-1:0]  best_score_o,
  output logic [IDX_W-1:0]    best_i_o,
  output logic [COORD_W-1:0]  best_j_o,
  output logic                overflow_o
);

  localparam int CNT_W = $clog2(N_PE + 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_q;
  logic [2*N_PE-1:0]  read_q;
  logic [PEN_W-1:0]   match_q, mm_q, gap_q;
  logic [COORD_W-1:0] j_q;

  logic               start_acc;
  logic               accept;

  // Systolic chain; index k feeds PE k, index k+1 is PE k's output
  logic [N_PE:0]        ch_vld;
  logic [2*N_PE+1:0]    base_pipe;
  logic [COORD_W-1:0]   ch_col [N_PE+1];
  logic [SCORE_W-1:0]   ch_h   [N_PE+1];
  logic [N_PE-1:0]      pe_en;
  logic [N_PE-1:0]      pe_ovf;
  logic [1:0]           drained_base_unused;  // last PE's base has nowhere to go

  logic                 cand_vld_d, cand_vld_q;
  logic [SCORE_W-1:0]   cand_h_d, cand_h_q;
  logic [IDX_W-1:0]     cand_i_d, cand_i_q;
  logic [COORD_W-1:0]   cand_j_d, cand_j_q;

  logic [SCORE_W-1:0]   best_score_q;
  logic [IDX_W-1:0]     best_i_q;
  logic [COORD_W-1:0]   best_j_q;
  logic                 ovf_q;

  assign start_acc = (state_q == ST_IDLE) & start_i;
  assign accept    = (state_q == ST_RUN) & ref_valid_i;

  assign ch_vld[0]           = accept;
  assign base_pipe[1:0]      = ref_base_i;
  assign ch_col[0]           = j_q;
  assign ch_h[0]             = '0;
  assign drained_base_unused = base_pipe[2*N_PE+1 -: 2];

  genvar k;
  for (k = 0; k < N_PE; k++) begin : g_pe
    assign pe_en[k] = (LEN_W'(k) < len_q);
    sw_pe #(
      .SCORE_W (SCORE_W),
      .PEN_W   (PEN_W),
      .COORD_W (COORD_W)
    ) u_pe (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (start_acc),
      .en_i        (pe_en[k]),
      .read_base_i (read_q[2*k +: 2]),
      .match_i     (match_q),
      .mismatch_i  (mm_q),
      .gap_i       (gap_q),
      .in_vld_i    (ch_vld[k]),
      .in_base_i   (base_pipe[2*k +: 2]),
      .in_col_i    (ch_col[k]),
      .in_h_i      (ch_h[k]),
      .out_vld_o   (ch_vld[k+1]),
      .out_base_o  (base_pipe[2*k+2 +: 2]),
      .out_col_o   (ch_col[k+1]),
      .out_h_o     (ch_h[k+1]),
      .out_ovf_o   (pe_ovf[k])
    );
  end

  // FSM state and drain countdown registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: DRAIN waits out the PE pipe plus the two max stages
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ref_valid_i && ref_last_i) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(N_PE + 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ch_vld[N_PE:1] == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration latched at start; column counter counts accepted bases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      read_q  <= '0;
      match_q <= '0;
      mm_q    <= '0;
      gap_q   <= '0;
      j_q     <= '0;
    end else if (start_acc) begin
      len_q   <= read_len_i;
      read_q  <= read_bases_i;
      match_q <= match_i;
      mm_q    <= mismatch_i;
      gap_q   <= gap_i;
      j_q     <= '0;
    end else if (accept) begin
      j_q <= j_q + 1'b1;
    end
  end

  // Same-cycle reduction: strict compare in ascending order keeps the lowest PE on ties
  always_comb begin
    cand_vld_d = 1'b0;
    cand_h_d   = '0;
    cand_i_d   = '0;
    cand_j_d   = '0;
    for (int p = 0; p < N_PE; p++) begin
      if (ch_vld[p+1] && pe_en[p] && (!cand_vld_d || (ch_h[p+1] > cand_h_d))) begin
        cand_vld_d = 1'b1;
        cand_h_d   = ch_h[p+1];
        cand_i_d   = IDX_W'(p);
        cand_j_d   = ch_col[p+1];
      end
    end
  end

  // Candidate register, then running best (strictly greater keeps the first hit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_vld_q   <= 1'b0;
      cand_h_q     <= '0;
      cand_i_q     <= '0;
      cand_j_q     <= '0;
      best_score_q <= '0;
      best_i_q     <= '0;
      best_j_q     <= '0;
      ovf_q        <= 1'b0;
    end else if (start_acc) begin
      cand_vld_q   <= 1'b0;
      best_score_q <= '0;
      best_i_q     <= '0;
      best_j_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      cand_vld_q <= cand_vld_d;
      cand_h_q   <= cand_h_d;
      cand_i_q   <= cand_i_d;
      cand_j_q   <= cand_j_d;
      if (cand_vld_q && (cand_h_q > best_score_q)) begin
        best_score_q <= cand_h_q;
        best_i_q     <= cand_i_q;
        best_j_q     <= cand_j_q;
      end
      if (|(pe_ovf & ch_vld[N_PE:1])) ovf_q <= 1'b1;
    end
  end

  assign ref_ready_o  = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign best_score_o = best_score_q;
  assign best_i_o     = best_i_q;
  assign best_j_o     = best_j_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_sw_linear_array.sv
// Directed bench for sw_linear_array with N_PE=4 (plus a SCORE_W=4 copy for saturation).
// Latency: checks done_o arrives N_PE+2 cycles after the last handshake.
// Backpressure: exercises bubbles on ref_valid_i, mid-run reset and ignored restart.
module tb_sw_linear_array;

  localparam int N_PE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  read_len_i;
  logic [7:0]  read_bases_i;
  logic [2:0]  match_i, mismatch_i, gap_i;
  logic        ref_valid_i;
  logic [1:0]  ref_base_i;
  logic        ref_last_i;

  logic        ref_ready_o, busy_o, done_o, overflow_o;
  logic [15:0] best_score_o;
  logic [1:0]  best_i_o;
  logic [15:0] best_j_o;

  logic        ref_ready4, busy4, done4, overflow4;
  logic [3:0]  best_score4;
  logic [1:0]  best_i4;
  logic [15:0] best_j4;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o) done_cnt++;

  sw_linear_array #(.N_PE(N_PE), .SCORE_W(16), .PEN_W(3), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .read_len_i(read_len_i),
    .read_bases_i(read_bases_i), .match_i(match_i), .mismatch_i(mismatch_i), .gap_i(gap_i),
    .ref_valid_i(ref_valid_i), .ref_base_i(ref_base_i), .ref_last_i(ref_last_i),
    .ref_ready_o(ref_ready_o), .busy_o(busy_o), .done_o(done_o),
    .best_score_o(best_score_o), .best_i_o(best_i_o), .best_j_o(best_j_o),
    .overflow_o(overflow_o)
  );

  sw_linear_array #(.N_PE(N_PE), .SCORE_W(4), .PEN_W(3), .COORD_W(16)) dut4 (
    .clk(clk), .rst(rst), .start_i(start_i), .read_len_i(read_len_i),
    .read_bases_i(read_bases_i), .match_i(match_i), .mismatch_i(mismatch_i), .gap_i(gap_i),
    .ref_valid_i(ref_valid_i), .ref_base_i(ref_base_i), .ref_last_i(ref_last_i),
    .ref_ready_o(ref_ready4), .busy_o(busy4), .done_o(done4),
    .best_score_o(best_score4), .best_i_o(best_i4), .best_j_o(best_j4),
    .overflow_o(overflow4)
  );

  typedef struct {
    logic [2:0] len;
    logic [7:0] rd;
    logic [7:0] rf;
    logic [2:0] m, mm, g;
    bit         bub;
    int         e_s, e_i, e_j, e_ov;
    bit         chk4;
    int         e4_s, e4_i, e4_j, e4_ov;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a run, optionally pulse start again while busy, stream 4 ref bases, wait for done_o
  task automatic do_run(input vec_t v, input bit dbl_start, output int lat);
    read_len_i   = v.len;
    read_bases_i = v.rd;
    match_i      = v.m;
    mismatch_i   = v.mm;
    gap_i        = v.g;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (dbl_start) begin
      start_i      = 1'b1;
      read_bases_i = 8'h00;
      read_len_i   = 3'd1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      if (v.bub) begin
        ref_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      ref_valid_i = 1'b1;
      ref_base_i  = v.rf[2*j +: 2];
      ref_last_i  = (j == 3);
      @(posedge clk); #1;
    end
    ref_valid_i = 1'b0;
    ref_last_i  = 1'b0;
    lat = 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v, input bit dbl_start);
    int lat;
    int d0;
    d0 = done_cnt;
    do_run(v, dbl_start, lat);
    chk({tag, "_latency"}, lat, N_PE + 2);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, done_o, 0);
    chk({tag, "_busy_after"}, busy_o, 0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_score"}, best_score_o, v.e_s);
    chk({tag, "_i"}, best_i_o, v.e_i);
    chk({tag, "_j"}, best_j_o, v.e_j);
    chk({tag, "_ovf"}, overflow_o, v.e_ov);
    if (v.chk4) begin
      chk({tag, "_sat_score"}, best_score4, v.e4_s);
      chk({tag, "_sat_i"}, best_i4, v.e4_i);
      chk({tag, "_sat_j"}, best_j4, v.e4_j);
      chk({tag, "_sat_ovf"}, overflow4, v.e4_ov);
    end
  endtask

  initial begin
    // len, read, ref, match, mismatch, gap, bubbles, expected (16-bit), check sat copy, expected (4-bit)
    vecs[0] = '{3'd4, 8'hE4, 8'hE4, 3'd2, 3'd1, 3'd2, 1'b0, 8,  3, 3, 0, 1'b0, 0,  0, 0, 0};
    vecs[1] = '{3'd4, 8'h00, 8'hFF, 3'd2, 3'd1, 3'd2, 1'b0, 0,  0, 0, 0, 1'b0, 0,  0, 0, 0};
    vecs[2] = '{3'd4, 8'hE4, 8'hE4, 3'd2, 3'd1, 3'd2, 1'b1, 8,  3, 3, 0, 1'b0, 0,  0, 0, 0};
    vecs[3] = '{3'd2, 8'h44, 8'h44, 3'd2, 3'd1, 3'd2, 1'b0, 4,  1, 1, 0, 1'b0, 0,  0, 0, 0};
    vecs[4] = '{3'd4, 8'h00, 8'h00, 3'd7, 3'd1, 3'd2, 1'b0, 28, 3, 3, 0, 1'b1, 15, 2, 2, 1};

    rst = 1'b1;
    start_i = 1'b0;
    read_len_i = '0;
    read_bases_i = '0;
    match_i = '0;
    mismatch_i = '0;
    gap_i = '0;
    ref_valid_i = 1'b0;
    ref_base_i = '0;
    ref_last_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ref_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_score", best_score_o, 0);
    chk("rst_i", best_i_o, 0);
    chk("rst_j", best_j_o, 0);
    chk("rst_ovf", overflow_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 5; n++) begin
      run_and_check($sformatf("vec%0d", n), vecs[n], 1'b0);
    end

    // Reset in the middle of a run: pipe and best are discarded, no done_o
    begin
      int d0;
      d0 = done_cnt;
      read_len_i = 3'd4;
      read_bases_i = 8'hE4;
      match_i = 3'd2;
      mismatch_i = 3'd1;
      gap_i = 3'd2;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("midrst_ready_before", ref_ready_o, 1);
      for (int j = 0; j < 2; j++) begin
        ref_valid_i = 1'b1;
        ref_base_i = read_bases_i[2*j +: 2];
        @(posedge clk); #1;
      end
      ref_valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", ref_ready_o, 0);
      chk("midrst_score", best_score_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (N_PE + 4) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle", busy_o, 0);
    end

    // Restart with a second start pulse while busy: only the first is honoured
    run_and_check("dblstart", vecs[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
